// File: rtl/ysyx_25040111_imem_rsp.sv
// Instruction-memory responder: single outstanding fetch, fixed (or LFSR-jittered) latency.
// Optional: define IMEM_RAND_DELAY_EN to add 0..7 cycles of pseudo-random delay per fetch.
//
// state  | meaning
// IDLE   | waiting for ifu_valid; accepts and latches the request address
// WAIT   | delay counter running; ifu_valid/ifu_addr ignored
// RESP   | ifu_ready strobe for one cycle, registered data/error presented
module ysyx_25040111_imem_rsp #(
  parameter int          AW_MEM  = 12,
  parameter logic [31:0] BASE    = 32'h80000000,
  parameter int          LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_valid,
  input  logic [31:0]       ifu_addr,
  output logic              ifu_ready,
  output logic [31:0]       ifu_inst,
  output logic              acc_err,
  input  logic              ld_en,
  input  logic [AW_MEM-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic        err_q;
  logic [31:0] mem [0:(1 << AW_MEM) - 1];

  logic [4:0]        load_val;
  logic [31:0]       rd_addr;
  logic [31:0]       rd_off;
  logic [31:0]       rd_idx;
  logic [AW_MEM-1:0] rd_widx;
  logic              rd_err;
  logic              enter_resp;

`ifdef IMEM_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign load_val = LAT_M1 + {2'b00, lfsr[2:0]};
`else
  assign load_val = LAT_M1;
`endif

  // The store is read on the edge that enters RESP; in IDLE that is the acceptance edge itself.
  assign rd_addr    = (state == S_IDLE) ? ifu_addr : addr_q;
  assign rd_off     = rd_addr - BASE;
  assign rd_idx     = rd_off >> 2;
  assign rd_widx    = rd_idx[AW_MEM-1:0];
  assign rd_err     = (rd_addr[1:0] != 2'b00) || (rd_idx[31:AW_MEM] != '0);
  assign enter_resp = ((state == S_IDLE) && ifu_valid && (load_val == 5'd0)) ||
                      ((state == S_WAIT) && (cnt == 5'd1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      addr_q <= 32'h0;
      inst_q <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ifu_valid) begin
            addr_q <= ifu_addr;
            cnt    <= load_val;
            state  <= (load_val != 5'd0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      inst_q <= (enter_resp && !rd_err) ? mem[rd_widx] : 32'h0;
      err_q  <= enter_resp && rd_err;
    end
  end

  // Store has no reset; a same-edge write is seen only by later reads.
  always_ff @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign ifu_ready = (state == S_RESP);
  assign ifu_inst  = inst_q;
  assign acc_err   = err_q;

endmodule

// File: tb/tb_ysyx_25040111_imem_rsp.sv
// Bench for ysyx_25040111_imem_rsp: directed fetch scenarios then randomized fetches
// checked against a word-array model of the store and the latency/error rules.
module tb_ysyx_25040111_imem_rsp;
  localparam int          AW   = 12;
  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h80000000;

  logic          clock = 1'b0;
  logic          reset;
  logic          ifu_valid;
  logic [31:0]   ifu_addr;
  logic          ifu_ready;
  logic [31:0]   ifu_inst;
  logic          acc_err;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [0:63];
  bit seen_lat [0:15];

  ysyx_25040111_imem_rsp #(.AW_MEM(AW), .BASE(BASE), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .ifu_valid(ifu_valid), .ifu_addr(ifu_addr),
    .ifu_ready(ifu_ready), .ifu_inst(ifu_inst), .acc_err(acc_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, {31'b0, ifu_ready}, 32'd0);
    chk({tag, "_inst"}, ifu_inst, 32'h0);
    chk({tag, "_err"}, {31'b0, acc_err}, 32'd0);
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    ld_en = 1'b1; ld_addr = AW'(idx); ld_data = data;
    step();
    ld_en = 1'b0;
    mdl[idx] = data;
  endtask

  // One fetch: returns after the cycle following the response.
  task automatic fetch(input logic [31:0] a, input bit scramble, input bit drop,
                       input bit wr_noise, input string tag);
    logic [31:0] off, wi, snap;
    bit e, got, leak;
    int lat, xfer, tgt;
    off = a - BASE;
    wi  = off >> 2;
    e   = (a[1:0] != 2'b00) || (wi >= 32'd4096);
    got = 0; leak = 0; lat = 0; xfer = 0; snap = 32'h0;
    ifu_valid = 1'b1;
    ifu_addr  = a;
    while (!got && lat < 40) begin
      snap = e ? 32'h0 : mdl[wi[5:0]];
      ld_en = 1'b0;
      if (wr_noise && $urandom_range(0, 1) == 1) begin
        tgt = (!e && $urandom_range(0, 1) == 1) ? int'(wi) : int'($urandom_range(0, 63));
        ld_en = 1'b1; ld_addr = AW'(tgt); ld_data = $urandom;
      end
      step();
      lat++;
      if (ld_en) mdl[ld_addr[5:0]] = ld_data;
      ld_en = 1'b0;
      if (ifu_valid && ifu_ready) xfer++;
      if (ifu_ready) begin
        got = 1;
        chk({tag, "_inst"}, ifu_inst, snap);
        chk({tag, "_err"}, {31'b0, acc_err}, {31'b0, e});
      end else begin
        if (ifu_inst != 32'h0 || acc_err != 1'b0) leak = 1;
        if (drop) ifu_valid = 1'b0;
        if (scramble) ifu_addr = a + 32'd4;
      end
    end
`ifdef IMEM_RAND_DELAY_EN
    chk({tag, "_lat_range"}, {31'b0, (lat >= LAT && lat <= LAT + 7)}, 32'd1);
    if (lat >= LAT && lat <= LAT + 7) seen_lat[lat - LAT] = 1'b1;
`else
    chk({tag, "_lat"}, lat, LAT);
`endif
    chk({tag, "_xfer"}, xfer, drop ? 0 : 1);
    chk({tag, "_quiet_wait"}, {31'b0, leak}, 32'd0);
    step();
    chk({tag, "_ready_1cyc"}, {31'b0, ifu_ready}, 32'd0);
    chk({tag, "_inst_idle"}, ifu_inst, 32'h0);
    ifu_valid = 1'b0;
  endtask

  initial begin
    int nrand, distinct, w, kind;
    logic [31:0] a;
    reset = 1'b1; ifu_valid = 1'b0; ifu_addr = 32'h0;
    ld_en = 1'b0; ld_addr = '0; ld_data = 32'h0;
    step(); step();
    check_quiet("reset");
    reset = 1'b0;

    preload(0, 32'h00000413);
    for (int i = 1; i < 64; i++) preload(i, $urandom);

    fetch(32'h80000000, 0, 0, 0, "basic_w0");
    fetch(32'h80000002, 0, 0, 0, "misaligned");
    fetch(32'h80004000, 0, 0, 0, "out_of_range");
    fetch(32'h7ffffffc, 0, 0, 0, "below_base");
    fetch(32'h80000004, 1, 0, 0, "addr_change");
    fetch(32'h80000010, 0, 1, 0, "drop");
    fetch(32'h80000014, 0, 0, 0, "after_drop");
    fetch(32'h800000fc, 0, 0, 0, "last_preloaded");

    // Reset one cycle after acceptance: no strobe, store preserved.
    ifu_valid = 1'b1; ifu_addr = 32'h80000018;
    step();
    reset = 1'b1; ifu_valid = 1'b0;
    step();
    check_quiet("rst_abort1");
    step();
    check_quiet("rst_abort2");
    reset = 1'b0;
    fetch(32'h8000001c, 0, 0, 0, "after_reset");

`ifdef IMEM_RAND_DELAY_EN
    nrand = 1000;
`else
    nrand = 200;
`endif
    for (int n = 0; n < nrand; n++) begin
      kind = int'($urandom_range(0, 9));
      w    = int'($urandom_range(0, 63));
      if (kind < 7)       a = BASE + 32'(w * 4);
      else if (kind == 7) a = BASE + 32'(w * 4) + 32'($urandom_range(1, 3));
      else if (kind == 8) a = BASE + 32'h4000 + 32'(w * 4);
      else                a = BASE - 32'(4 * (w + 1));
      fetch(a, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, 1, "rand");
    end

`ifdef IMEM_RAND_DELAY_EN
    distinct = 0;
    for (int i = 0; i < 16; i++) if (seen_lat[i]) distinct++;
    chk("distinct_latencies", {31'b0, distinct >= 4}, 32'd1);
`else
    distinct = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
